// File: rtl/core_mem_arb_if.sv
// Avalon-MM style master port bundle; one instance per arbiter master (CPU data port, host window).
interface core_mem_arb_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]             address;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    read;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    waitrequest;

  modport master (output address, write, writedata, byteenable, read,
                  input  readdata, waitrequest);
  modport slave  (input  address, write, writedata, byteenable, read,
                  output readdata, waitrequest);
endinterface

// File: rtl/core_mem_arb.sv
// Two-master arbiter (CPU data port c, host window h) in front of one single-port synchronous RAM.
// Define CORE_MEM_ARB_RR_EN for round-robin tie breaking; otherwise the CPU always wins a tie.
module core_mem_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  core_mem_arb_if.slave           c,
  core_mem_arb_if.slave           h,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    mem_rd,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("core_mem_arb: RD_LATENCY must be in the range 1..4");
    end
  endgenerate

  logic [0:0]            state;
  logic                  grant;
  logic [2:0]            lat_cnt;
  logic                  req_c;
  logic                  req_h;
  logic                  any_req;
  logic                  win_h;
  logic                  sel_h;
  logic                  sel_write;
  logic                  rd_done;
  logic                  c_wait;
  logic                  h_wait;
  logic [BE_WIDTH-1:0]   sel_be;
  logic                  unused_addr_bits;

  assign req_c   = c.read | c.write;
  assign req_h   = h.read | h.write;
  assign any_req = req_c | req_h;

`ifdef CORE_MEM_ARB_RR_EN
  logic last_grant;

  // On a tie the master that did not take the previous grant gets the bank.
  assign win_h = req_h & (~req_c | ~last_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_grant <= win_h;
    end
  end
`else
  assign win_h = req_h & ~req_c;
`endif

  // While a read is outstanding the latched grant keeps steering the RAM address.
  assign sel_h     = (state == RD_WAIT) ? grant : win_h;
  assign sel_write = sel_h ? h.write : c.write;
  assign sel_be    = sel_h ? h.byteenable : c.byteenable;
  assign rd_done   = (state == RD_WAIT) && (lat_cnt == 3'd0);

  assign mem_addr  = sel_h ? h.address[ADDR_WIDTH+1:2] : c.address[ADDR_WIDTH+1:2];
  assign mem_wdata = sel_h ? h.writedata : c.writedata;
  assign mem_be    = (state == IDLE && sel_write) ? sel_be : '1;
  assign mem_wr    = ~reset & (state == IDLE) & any_req & sel_write;
  assign mem_rd    = ~reset & (state == IDLE) & any_req & ~sel_write;

  assign c.readdata = mem_rdata;
  assign h.readdata = mem_rdata;

  assign unused_addr_bits = ^{c.address[31:ADDR_WIDTH+2], c.address[1:0],
                              h.address[31:ADDR_WIDTH+2], h.address[1:0]};

  // A pending master stalls unless it is the IDLE writer or the read owner in its final wait cycle.
  always_comb begin
    c_wait = req_c;
    h_wait = req_h;
    if (reset) begin
      c_wait = 1'b1;
      h_wait = 1'b1;
    end else if (state == IDLE) begin
      if (any_req) begin
        if (win_h) h_wait = ~h.write;
        else       c_wait = ~c.write;
      end
    end else if (rd_done) begin
      if (grant) h_wait = 1'b0;
      else       c_wait = 1'b0;
    end
  end

  assign c.waitrequest = c_wait;
  assign h.waitrequest = h_wait;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= 1'b0;
      lat_cnt <= 3'd0;
    end else if (state == IDLE) begin
      if (any_req) begin
        grant <= win_h;
        if (!sel_write) begin
          state   <= RD_WAIT;
          lat_cnt <= 3'(RD_LATENCY - 1);
        end
      end
    end else begin
      if (lat_cnt == 3'd0) state <= IDLE;
      else                 lat_cnt <= lat_cnt - 3'd1;
    end
  end
endmodule

// File: tb/tb_core_mem_arb.sv
// Bench for core_mem_arb: three instances with RD_LATENCY 1, 2 and 3, each with its own RAM model.
// Expected behaviour comes from a transaction-level model of bank occupancy and arbitration.
module tb_core_mem_arb;
  localparam int ND = 3;
`ifdef CORE_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]    c_addr [ND];
  logic [31:0]    c_wdata [ND];
  logic [3:0]     c_be [ND];
  logic [31:0]    h_addr [ND];
  logic [31:0]    h_wdata [ND];
  logic [3:0]     h_be [ND];
  logic [ND-1:0]  c_wr, c_rd, h_wr, h_rd;
  logic [ND-1:0]  c_wait, h_wait, m_wr, m_rd;
  logic [31:0]    c_rdata [ND];
  logic [31:0]    h_rdata [ND];
  logic [11:0]    m_addr [ND];
  logic [3:0]     m_be [ND];
  logic [31:0]    model_mem [ND][4096];
  int checks = 0;
  int fails = 0;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    core_mem_arb_if #(.DATA_WIDTH(32)) c_if ();
    core_mem_arb_if #(.DATA_WIDTH(32)) h_if ();
    logic [31:0] ram [4096];
    logic [31:0] pipe [3];
    logic [11:0] maddr;
    logic        mwr, mrd;
    logic [3:0]  mbe;
    logic [31:0] mwdata;

    assign c_if.address    = c_addr[g];
    assign c_if.write      = c_wr[g];
    assign c_if.writedata  = c_wdata[g];
    assign c_if.byteenable = c_be[g];
    assign c_if.read       = c_rd[g];
    assign h_if.address    = h_addr[g];
    assign h_if.write      = h_wr[g];
    assign h_if.writedata  = h_wdata[g];
    assign h_if.byteenable = h_be[g];
    assign h_if.read       = h_rd[g];
    assign c_wait[g]  = c_if.waitrequest;
    assign h_wait[g]  = h_if.waitrequest;
    assign c_rdata[g] = c_if.readdata;
    assign h_rdata[g] = h_if.readdata;
    assign m_wr[g]    = mwr;
    assign m_rd[g]    = mrd;
    assign m_addr[g]  = maddr;
    assign m_be[g]    = mbe;

    core_mem_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .RD_LATENCY(g + 1)) dut (
      .clk(clk), .reset(reset), .c(c_if), .h(h_if),
      .mem_addr(maddr), .mem_wr(mwr), .mem_be(mbe), .mem_wdata(mwdata),
      .mem_rd(mrd), .mem_rdata(pipe[g])
    );

    initial for (int i = 0; i < 4096; i++) ram[i] = 32'h5A00_0000 | i;

    always @(posedge clk) begin
      if (mwr) ram[maddr] <= (ram[maddr] & ~be_mask(mbe)) | (mwdata & be_mask(mbe));
      pipe[0] <= ram[maddr];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic clear_inputs();
    for (int d = 0; d < ND; d++) begin
      c_addr[d] = '0; c_wdata[d] = '0; c_be[d] = 4'hF; c_wr[d] = 1'b0; c_rd[d] = 1'b0;
      h_addr[d] = '0; h_wdata[d] = '0; h_be[d] = 4'hF; h_wr[d] = 1'b0; h_rd[d] = 1'b0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin c_rd[d] = 1'b1; h_wr[d] = 1'b1; end
    @(negedge clk); #1;
    for (int d = 0; d < ND; d++) begin
      checks++; if (c_wait[d] !== 1'b1) begin fails++; $display("[TB] FAIL reset_c_wait dut%0d: got %b expected 1", d, c_wait[d]); end
      checks++; if (h_wait[d] !== 1'b1) begin fails++; $display("[TB] FAIL reset_h_wait dut%0d: got %b expected 1", d, h_wait[d]); end
      checks++; if (m_wr[d] !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_wr dut%0d: got %b expected 0", d, m_wr[d]); end
      checks++; if (m_rd[d] !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_rd dut%0d: got %b expected 0", d, m_rd[d]); end
    end
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++; if (c_wait[d] !== 1'b0) begin fails++; $display("[TB] FAIL idle_c_wait dut%0d: got %b expected 0", d, c_wait[d]); end
      checks++; if (h_wait[d] !== 1'b0) begin fails++; $display("[TB] FAIL idle_h_wait dut%0d: got %b expected 0", d, h_wait[d]); end
    end
    @(negedge clk);
  endtask

  task automatic test_lat1_read();
    do_reset();
    h_addr[0] = 32'h0000_0010; h_wr[0] = 1'b1; h_wdata[0] = 32'hDEAD_BEEF;
    #1;
    checks++; if (h_wait[0] !== 1'b0) begin fails++; $display("[TB] FAIL lat1_host_write_wait: got %b expected 0", h_wait[0]); end
    @(negedge clk);
    model_mem[0][4] = 32'hDEAD_BEEF;
    clear_inputs();
    c_addr[0] = 32'h0000_0010; c_rd[0] = 1'b1;
    #1;
    checks++; if (c_wait[0] !== 1'b1) begin fails++; $display("[TB] FAIL lat1_c_wait_T: got %b expected 1", c_wait[0]); end
    checks++; if (m_rd[0] !== 1'b1) begin fails++; $display("[TB] FAIL lat1_mem_rd_T: got %b expected 1", m_rd[0]); end
    checks++; if (m_addr[0] !== 12'd4) begin fails++; $display("[TB] FAIL lat1_mem_addr: got %0d expected 4", m_addr[0]); end
    @(negedge clk); #1;
    checks++; if (c_wait[0] !== 1'b0) begin fails++; $display("[TB] FAIL lat1_c_wait_T1: got %b expected 0", c_wait[0]); end
    checks++; if (m_rd[0] !== 1'b0) begin fails++; $display("[TB] FAIL lat1_mem_rd_T1: got %b expected 0", m_rd[0]); end
    checks++; if (c_rdata[0] !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL lat1_rdata: got %h expected deadbeef", c_rdata[0]); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_lat3_read();
    do_reset();
    h_addr[2] = 32'h0000_0020; h_rd[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (h_wait[2] !== (k < 3)) begin fails++; $display("[TB] FAIL lat3_h_wait cycle%0d: got %b expected %b", k, h_wait[2], k < 3); end
      checks++; if (m_addr[2] !== 12'd8) begin fails++; $display("[TB] FAIL lat3_mem_addr cycle%0d: got %0d expected 8", k, m_addr[2]); end
      checks++; if (m_rd[2] !== (k == 0)) begin fails++; $display("[TB] FAIL lat3_mem_rd cycle%0d: got %b expected %b", k, m_rd[2], k == 0); end
      if (k == 3) begin
        checks++; if (h_rdata[2] !== model_mem[2][8]) begin fails++; $display("[TB] FAIL lat3_rdata: got %h expected %h", h_rdata[2], model_mem[2][8]); end
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_tie_merge();
    logic [31:0] merged;
    do_reset();
    merged = (model_mem[1][1] & 32'hFFFF_0000) | 32'h0000_3344;
    c_addr[1] = 32'h0000_0004; c_wr[1] = 1'b1; c_wdata[1] = 32'h1122_3344; c_be[1] = 4'b0011;
    h_addr[1] = 32'h0000_0004; h_rd[1] = 1'b1;
    #1;
    checks++; if (c_wait[1] !== 1'b0) begin fails++; $display("[TB] FAIL tie_c_wait_T: got %b expected 0", c_wait[1]); end
    checks++; if (h_wait[1] !== 1'b1) begin fails++; $display("[TB] FAIL tie_h_wait_T: got %b expected 1", h_wait[1]); end
    checks++; if (m_wr[1] !== 1'b1) begin fails++; $display("[TB] FAIL tie_mem_wr_T: got %b expected 1", m_wr[1]); end
    checks++; if (m_be[1] !== 4'b0011) begin fails++; $display("[TB] FAIL tie_mem_be_T: got %b expected 0011", m_be[1]); end
    @(negedge clk);
    model_mem[1][1] = merged;
    c_wr[1] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++; if (h_wait[1] !== (k < 3)) begin fails++; $display("[TB] FAIL tie_h_wait cycle%0d: got %b expected %b", k, h_wait[1], k < 3); end
      checks++; if (m_rd[1] !== (k == 1)) begin fails++; $display("[TB] FAIL tie_mem_rd cycle%0d: got %b expected %b", k, m_rd[1], k == 1); end
      if (k == 3) begin
        checks++; if (h_rdata[1] !== merged) begin fails++; $display("[TB] FAIL tie_merged_rdata: got %h expected %h", h_rdata[1], merged); end
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_tie_writes();
    int cn;
    int hn;
    bit exp_h;
    do_reset();
    cn = 0;
    hn = 0;
    for (int k = 0; k < 6; k++) begin
      c_addr[0] = 32'(32 + cn) << 2; c_wr[0] = 1'b1; c_wdata[0] = 32'hC0DE_0000 | cn;
      h_addr[0] = 32'(48 + hn) << 2; h_wr[0] = 1'b1; h_wdata[0] = 32'hB0B0_0000 | hn;
      #1;
      exp_h = RR && (k % 2 == 1);
      checks++; if (c_wait[0] !== exp_h) begin fails++; $display("[TB] FAIL ties_c_wait cycle%0d: got %b expected %b", k, c_wait[0], exp_h); end
      checks++; if (h_wait[0] !== !exp_h) begin fails++; $display("[TB] FAIL ties_h_wait cycle%0d: got %b expected %b", k, h_wait[0], !exp_h); end
      checks++; if (m_wr[0] !== 1'b1) begin fails++; $display("[TB] FAIL ties_mem_wr cycle%0d: got %b expected 1", k, m_wr[0]); end
      checks++; if (m_addr[0] !== 12'(exp_h ? 48 + hn : 32 + cn)) begin fails++; $display("[TB] FAIL ties_mem_addr cycle%0d: got %0d expected %0d", k, m_addr[0], exp_h ? 48 + hn : 32 + cn); end
      if (exp_h) begin model_mem[0][48 + hn] = h_wdata[0]; hn++; end
      else       begin model_mem[0][32 + cn] = c_wdata[0]; cn++; end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_rw_same();
    do_reset();
    c_addr[0] = 32'h0000_0008; c_wr[0] = 1'b1; c_rd[0] = 1'b1; c_wdata[0] = 32'hA5A5_A5A5;
    #1;
    checks++; if (c_wait[0] !== 1'b0) begin fails++; $display("[TB] FAIL rw_c_wait: got %b expected 0", c_wait[0]); end
    checks++; if (m_wr[0] !== 1'b1) begin fails++; $display("[TB] FAIL rw_mem_wr: got %b expected 1", m_wr[0]); end
    checks++; if (m_rd[0] !== 1'b0) begin fails++; $display("[TB] FAIL rw_mem_rd: got %b expected 0", m_rd[0]); end
    @(negedge clk);
    model_mem[0][2] = 32'hA5A5_A5A5;
    c_wr[0] = 1'b0;
    #1;
    checks++; if (m_rd[0] !== 1'b1) begin fails++; $display("[TB] FAIL rw_followup_mem_rd: got %b expected 1", m_rd[0]); end
    @(negedge clk); #1;
    checks++; if (c_wait[0] !== 1'b0) begin fails++; $display("[TB] FAIL rw_followup_c_wait: got %b expected 0", c_wait[0]); end
    checks++; if (c_rdata[0] !== 32'hA5A5_A5A5) begin fails++; $display("[TB] FAIL rw_readback: got %h expected a5a5a5a5", c_rdata[0]); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    c_addr[1] = 32'h0000_000C; c_rd[1] = 1'b1;
    #1;
    checks++; if (m_rd[1] !== 1'b1) begin fails++; $display("[TB] FAIL midrst_mem_rd_T: got %b expected 1", m_rd[1]); end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (c_wait[1] !== 1'b1) begin fails++; $display("[TB] FAIL midrst_c_wait: got %b expected 1", c_wait[1]); end
      checks++; if (h_wait[1] !== 1'b1) begin fails++; $display("[TB] FAIL midrst_h_wait: got %b expected 1", h_wait[1]); end
      checks++; if (m_rd[1] !== 1'b0) begin fails++; $display("[TB] FAIL midrst_mem_rd: got %b expected 0", m_rd[1]); end
      @(negedge clk);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (c_wait[1] !== (k < 2)) begin fails++; $display("[TB] FAIL reissue_c_wait cycle%0d: got %b expected %b", k, c_wait[1], k < 2); end
      checks++; if (m_rd[1] !== (k == 0)) begin fails++; $display("[TB] FAIL reissue_mem_rd cycle%0d: got %b expected %b", k, m_rd[1], k == 0); end
      if (k == 2) begin
        checks++; if (c_rdata[1] !== model_mem[1][3]) begin fails++; $display("[TB] FAIL reissue_rdata: got %h expected %h", c_rdata[1], model_mem[1][3]); end
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_random(input int d);
    bit          act [2];
    bit          owr [2];
    bit          ord [2];
    logic [31:0] oaddr [2];
    logic [31:0] odata [2];
    logic [3:0]  obe [2];
    bit          ew [2];
    bit          emwr, emrd;
    int          free_at, owner, last, w, kind;
    logic [31:0] rd_exp, junk, got;
    logic [11:0] word;
    do_reset();
    free_at = 0; owner = 0; last = 1; w = 0; rd_exp = '0;
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; owr[m] = 1'b0; ord[m] = 1'b0; oaddr[m] = '0; odata[m] = '0; obe[m] = 4'hF;
    end
    for (int n = 0; n < 300; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!act[m] && $urandom_range(3) != 0) begin
          kind = $urandom_range(2);
          act[m] = 1'b1;
          owr[m] = (kind != 0);
          ord[m] = (kind != 1);
          junk = $urandom;
          word = 12'($urandom_range(15));
          oaddr[m] = {junk[31:14], word, junk[1:0]};
          odata[m] = $urandom;
          obe[m] = (m == 1) ? 4'hF : 4'($urandom_range(15, 1));
        end
      end
      c_addr[d] = oaddr[0]; c_wr[d] = act[0] & owr[0]; c_rd[d] = act[0] & ord[0]; c_wdata[d] = odata[0]; c_be[d] = obe[0];
      h_addr[d] = oaddr[1]; h_wr[d] = act[1] & owr[1]; h_rd[d] = act[1] & ord[1]; h_wdata[d] = odata[1]; h_be[d] = obe[1];
      #1;
      ew[0] = act[0]; ew[1] = act[1]; emwr = 1'b0; emrd = 1'b0;
      if (n < free_at) begin
        if (n == free_at - 1) begin
          ew[owner] = 1'b0;
          got = (owner == 0) ? c_rdata[d] : h_rdata[d];
          checks++; if (got !== rd_exp) begin fails++; $display("[TB] FAIL rand_rdata dut%0d cycle%0d: got %h expected %h", d, n, got, rd_exp); end
        end
      end else if (act[0] || act[1]) begin
        w = (act[0] && act[1]) ? (RR ? 1 - last : 0) : (act[1] ? 1 : 0);
        last = w;
        if (owr[w]) begin
          ew[w] = 1'b0;
          emwr = 1'b1;
        end else begin
          emrd = 1'b1;
          owner = w;
          free_at = n + d + 2;
          rd_exp = model_mem[d][oaddr[w][13:2]];
        end
      end
      checks++; if (c_wait[d] !== ew[0]) begin fails++; $display("[TB] FAIL rand_c_wait dut%0d cycle%0d: got %b expected %b", d, n, c_wait[d], ew[0]); end
      checks++; if (h_wait[d] !== ew[1]) begin fails++; $display("[TB] FAIL rand_h_wait dut%0d cycle%0d: got %b expected %b", d, n, h_wait[d], ew[1]); end
      checks++; if (m_wr[d] !== emwr) begin fails++; $display("[TB] FAIL rand_mem_wr dut%0d cycle%0d: got %b expected %b", d, n, m_wr[d], emwr); end
      checks++; if (m_rd[d] !== emrd) begin fails++; $display("[TB] FAIL rand_mem_rd dut%0d cycle%0d: got %b expected %b", d, n, m_rd[d], emrd); end
      if (emwr) begin
        model_mem[d][oaddr[w][13:2]] = (model_mem[d][oaddr[w][13:2]] & ~be_mask(obe[w])) | (odata[w] & be_mask(obe[w]));
      end
      for (int m = 0; m < 2; m++) if (act[m] && !ew[m]) act[m] = 1'b0;
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 4096; i++) model_mem[d][i] = 32'h5A00_0000 | i;
    $display("[TB] starting, round-robin build = %0d", RR);
    test_reset();
    test_lat1_read();
    test_lat3_read();
    test_tie_merge();
    test_tie_writes();
    test_rw_same();
    test_reset_mid_read();
    for (int d = 0; d < ND; d++) test_random(d);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
